// File: rtl/mem_stage_pkg.sv
// Shared LC-3b type definitions used by the MEM stage and its helpers.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldw  = 4'b0110,
    op_stw  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef enum logic {
    PH_DIRECT   = 1'b0,
    PH_INDIRECT = 1'b1
  } mem_phase_t;

endpackage

// File: rtl/mem_stage_byte_align.sv
// Byte-lane helper: write mask / replicated store data and zero-extended load byte.
module mem_byte_align
  import lc3b_types::*;
(
  input  logic          byte_store,
  input  logic          addr_lsb,
  input  lc3b_word      store_data,
  input  lc3b_word      rdata,
  output lc3b_mem_wmask wmask,
  output lc3b_word      wdata,
  output lc3b_word      load_byte
);

  always_comb begin
    wmask = 2'b11;
    wdata = store_data;
    if (byte_store) begin
      wmask = addr_lsb ? 2'b10 : 2'b01;
      wdata = {store_data[7:0], store_data[7:0]};
    end
    load_byte = addr_lsb ? {8'h00, rdata[15:8]} : {8'h00, rdata[7:0]};
  end

endmodule

// File: rtl/mem_stage.sv
// LC-3b MEM stage: D-cache handshake, two-phase LDI/STI sequencer, MEM/WB register.
module mem_stage
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_mem,
  input  logic [3:0]    opcode_mem,
  input  lc3b_word      pc_mem,
  input  lc3b_word      alu_out_mem,
  input  lc3b_word      sr2_mem,
  input  lc3b_reg       dest_mem,
  input  logic          ld_reg_mem,
  output lc3b_word      D_mem_address,
  output logic          D_mem_read,
  output logic          D_mem_write,
  output lc3b_mem_wmask mem_byte_enable,
  output lc3b_word      D_mem_wdata,
  input  logic          D_mem_resp,
  input  lc3b_word      D_mem_rdata,
  output logic          stall_mem,
  output logic          valid_wb,
  output logic [3:0]    opcode_wb,
  output lc3b_word      pc_wb,
  output lc3b_word      alu_out_wb,
  output lc3b_word      mem_data_wb,
  output lc3b_reg       dest_wb,
  output logic          ld_reg_wb
);

  mem_phase_t phase_q, phase_d;
  lc3b_word   ind_addr_q, ind_addr_d;

  logic       valid_wb_q, valid_wb_d;
  logic [3:0] opcode_wb_q, opcode_wb_d;
  lc3b_word   pc_wb_q, pc_wb_d;
  lc3b_word   alu_out_wb_q, alu_out_wb_d;
  lc3b_word   mem_data_wb_q, mem_data_wb_d;
  lc3b_reg    dest_wb_q, dest_wb_d;
  logic       ld_reg_wb_q, ld_reg_wb_d;

  logic     is_memop, is_mem, is_ind, is_byte, is_ldb, is_stb, is_word_load;
  logic     is_store_final, use_ind, final_ph;
  lc3b_word addr_raw, load_byte, load_result;

  always_comb begin
    is_memop     = 1'b0;
    is_ind       = 1'b0;
    is_ldb       = 1'b0;
    is_stb       = 1'b0;
    is_word_load = 1'b0;
    case (opcode_mem)
      op_ldb: begin is_memop = 1'b1; is_ldb = 1'b1; end
      op_stb: begin is_memop = 1'b1; is_stb = 1'b1; end
      op_ldw: begin is_memop = 1'b1; is_word_load = 1'b1; end
      op_stw: is_memop = 1'b1;
      op_ldi: begin is_memop = 1'b1; is_ind = 1'b1; is_word_load = 1'b1; end
      op_sti: begin is_memop = 1'b1; is_ind = 1'b1; end
      default: ;
    endcase
    // Gating with reset makes the request drop combinationally during reset.
    is_mem   = reset & valid_mem & is_memop;
    is_byte  = is_ldb | is_stb;
    use_ind  = is_ind & (phase_q == PH_INDIRECT);
    final_ph = ~is_ind | use_ind;
    addr_raw = use_ind ? ind_addr_q : alu_out_mem;
    is_store_final = (opcode_mem == op_stw) | is_stb | ((opcode_mem == op_sti) & use_ind);
  end

  mem_byte_align u_align (
    .byte_store (is_stb),
    .addr_lsb   (addr_raw[0]),
    .store_data (sr2_mem),
    .rdata      (D_mem_rdata),
    .wmask      (mem_byte_enable),
    .wdata      (D_mem_wdata),
    .load_byte  (load_byte)
  );

  assign D_mem_address = is_byte ? addr_raw : {addr_raw[15:1], 1'b0};
  assign D_mem_write   = is_mem & is_store_final;
  assign D_mem_read    = is_mem & ~is_store_final;
  assign stall_mem     = is_mem & ~(D_mem_resp & final_ph);

  always_comb begin
    phase_d    = phase_q;
    ind_addr_d = ind_addr_q;
    if (is_mem && is_ind) begin
      if (D_mem_resp) begin
        if (phase_q == PH_DIRECT) begin
          phase_d    = PH_INDIRECT;
          ind_addr_d = D_mem_rdata;
        end else begin
          phase_d = PH_DIRECT;
        end
      end
    end else begin
      phase_d = PH_DIRECT;
    end
  end

  always_comb begin
    load_result = '0;
    if (is_mem && is_ldb)
      load_result = load_byte;
    else if (is_mem && is_word_load)
      load_result = D_mem_rdata;

    valid_wb_d    = 1'b0;
    opcode_wb_d   = opcode_wb_q;
    pc_wb_d       = pc_wb_q;
    alu_out_wb_d  = alu_out_wb_q;
    mem_data_wb_d = mem_data_wb_q;
    dest_wb_d     = dest_wb_q;
    ld_reg_wb_d   = ld_reg_wb_q;
    if (!stall_mem) begin
      valid_wb_d    = valid_mem;
      opcode_wb_d   = opcode_mem;
      pc_wb_d       = pc_mem;
      alu_out_wb_d  = alu_out_mem;
      mem_data_wb_d = load_result;
      dest_wb_d     = dest_mem;
      ld_reg_wb_d   = ld_reg_mem;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q       <= PH_DIRECT;
      ind_addr_q    <= '0;
      valid_wb_q    <= 1'b0;
      opcode_wb_q   <= '0;
      pc_wb_q       <= '0;
      alu_out_wb_q  <= '0;
      mem_data_wb_q <= '0;
      dest_wb_q     <= '0;
      ld_reg_wb_q   <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      ind_addr_q    <= ind_addr_d;
      valid_wb_q    <= valid_wb_d;
      opcode_wb_q   <= opcode_wb_d;
      pc_wb_q       <= pc_wb_d;
      alu_out_wb_q  <= alu_out_wb_d;
      mem_data_wb_q <= mem_data_wb_d;
      dest_wb_q     <= dest_wb_d;
      ld_reg_wb_q   <= ld_reg_wb_d;
    end
  end

  assign valid_wb    = valid_wb_q;
  assign opcode_wb   = opcode_wb_q;
  assign pc_wb       = pc_wb_q;
  assign alu_out_wb  = alu_out_wb_q;
  assign mem_data_wb = mem_data_wb_q;
  assign dest_wb     = dest_wb_q;
  assign ld_reg_wb   = ld_reg_wb_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed instructions push expected MEM/WB contents,
// a monitor pops and compares whenever valid_wb is presented.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid_mem = 1'b0;
  logic [3:0]  opcode_mem = '0;
  logic [15:0] pc_mem = '0, alu_out_mem = '0, sr2_mem = '0;
  logic [2:0]  dest_mem = '0;
  logic        ld_reg_mem = 1'b0;
  logic [15:0] D_mem_address, D_mem_wdata;
  logic        D_mem_read, D_mem_write;
  logic [1:0]  mem_byte_enable;
  logic        D_mem_resp = 1'b0;
  logic [15:0] D_mem_rdata = 16'hDEAD;
  logic        stall_mem, valid_wb, ld_reg_wb;
  logic [3:0]  opcode_wb;
  logic [15:0] pc_wb, alu_out_wb, mem_data_wb;
  logic [2:0]  dest_wb;

  mem_stage dut (
    .clk(clk), .reset(reset), .valid_mem(valid_mem), .opcode_mem(opcode_mem),
    .pc_mem(pc_mem), .alu_out_mem(alu_out_mem), .sr2_mem(sr2_mem), .dest_mem(dest_mem),
    .ld_reg_mem(ld_reg_mem), .D_mem_address(D_mem_address), .D_mem_read(D_mem_read),
    .D_mem_write(D_mem_write), .mem_byte_enable(mem_byte_enable), .D_mem_wdata(D_mem_wdata),
    .D_mem_resp(D_mem_resp), .D_mem_rdata(D_mem_rdata), .stall_mem(stall_mem),
    .valid_wb(valid_wb), .opcode_wb(opcode_wb), .pc_wb(pc_wb), .alu_out_wb(alu_out_wb),
    .mem_data_wb(mem_data_wb), .dest_wb(dest_wb), .ld_reg_wb(ld_reg_wb)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] pc;
    logic [15:0] alu;
    logic [15:0] mdata;
    logic [2:0]  dest;
    logic        ldreg;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  localparam logic [3:0] ADD = 4'b0001, LDB = 4'b0010, STB = 4'b0011, LDW = 4'b0110,
                         STW = 4'b0111, LDI = 4'b1010, STI = 4'b1011;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [15:0] pc, input logic [15:0] alu,
                       input logic [15:0] sr2, input logic [2:0] dest, input logic ldreg,
                       input logic [15:0] mdata);
    valid_mem   = 1'b1;
    opcode_mem  = op;
    pc_mem      = pc;
    alu_out_mem = alu;
    sr2_mem     = sr2;
    dest_mem    = dest;
    ld_reg_mem  = ldreg;
    D_mem_resp  = 1'b0;
    sb.push_back('{op: op, pc: pc, alu: alu, mdata: mdata, dest: dest, ldreg: ldreg});
  endtask

  task automatic req(input string name, input logic [15:0] addr, input logic rd,
                     input logic wr, input logic [1:0] be);
    #1;
    chk({name, "_addr"}, {16'h0, D_mem_address}, {16'h0, addr});
    chk({name, "_rdwr"}, {30'h0, D_mem_read, D_mem_write}, {30'h0, rd, wr});
    chk({name, "_be"}, {30'h0, mem_byte_enable}, {30'h0, be});
  endtask

  // One access phase: response arrives lat cycles after issue.
  task automatic phase(input string name, input int lat, input logic [15:0] rd,
                       input logic final_ph);
    for (int c = 0; c <= lat; c++) begin
      D_mem_resp  = (c == lat);
      D_mem_rdata = (c == lat) ? rd : 16'hDEAD;
      #1;
      chk({name, "_stall"}, {31'h0, stall_mem}, {31'h0, !((c == lat) && final_ph)});
      if (c > 0) chk({name, "_bubble"}, {31'h0, valid_wb}, 32'h0);
      @(negedge clk);
    end
    D_mem_resp  = 1'b0;
    D_mem_rdata = 16'hDEAD;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid_wb) begin
        if (sb.size() == 0) begin
          chk("wb_unexpected", {31'h0, valid_wb}, 32'h0);
        end else begin
          e = sb.pop_front();
          chk("wb_ctl", {24'h0, opcode_wb, dest_wb, ld_reg_wb}, {24'h0, e.op, e.dest, e.ldreg});
          chk("wb_pc", {16'h0, pc_wb}, {16'h0, e.pc});
          chk("wb_alu", {16'h0, alu_out_wb}, {16'h0, e.alu});
          chk("wb_mdata", {16'h0, mem_data_wb}, {16'h0, e.mdata});
        end
      end
    end
  end

  initial begin : stim
    #2;
    chk("rst_req", {30'h0, D_mem_read, D_mem_write}, 32'h0);
    chk("rst_wb", {16'h0, alu_out_wb}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    drive(ADD, 16'h0100, 16'h1234, 16'h0000, 3'd3, 1'b1, 16'h0000);
    #1;
    chk("add_req", {30'h0, D_mem_read, D_mem_write}, 32'h0);
    chk("add_stall", {31'h0, stall_mem}, 32'h0);
    @(negedge clk);

    drive(LDW, 16'h0102, 16'h3001, 16'h0000, 3'd1, 1'b1, 16'hBEEF);
    req("ldw", 16'h3000, 1'b1, 1'b0, 2'b11);
    phase("ldw", 3, 16'hBEEF, 1'b1);

    drive(STB, 16'h0104, 16'h4005, 16'h00A7, 3'd0, 1'b0, 16'h0000);
    req("stb_odd", 16'h4005, 1'b0, 1'b1, 2'b10);
    chk("stb_wdata", {16'h0, D_mem_wdata}, 32'h0000A7A7);
    phase("stb_odd", 1, 16'h0000, 1'b1);

    drive(STB, 16'h0106, 16'h4004, 16'h1234, 3'd0, 1'b0, 16'h0000);
    req("stb_even", 16'h4004, 1'b0, 1'b1, 2'b01);
    chk("stb_even_wdata", {16'h0, D_mem_wdata}, 32'h00003434);
    phase("stb_even", 0, 16'h0000, 1'b1);

    drive(LDB, 16'h0108, 16'h4005, 16'h0000, 3'd2, 1'b1, 16'h00A7);
    req("ldb_odd", 16'h4005, 1'b1, 1'b0, 2'b11);
    phase("ldb_odd", 2, 16'hA7C3, 1'b1);

    drive(LDB, 16'h010A, 16'h4004, 16'h0000, 3'd2, 1'b1, 16'h00C3);
    req("ldb_even", 16'h4004, 1'b1, 1'b0, 2'b11);
    phase("ldb_even", 0, 16'hA7C3, 1'b1);

    drive(LDI, 16'h010C, 16'h5000, 16'h0000, 3'd4, 1'b1, 16'h1111);
    req("ldi_ptr", 16'h5000, 1'b1, 1'b0, 2'b11);
    phase("ldi_ptr", 1, 16'h6002, 1'b0);
    req("ldi_fin", 16'h6002, 1'b1, 1'b0, 2'b11);
    phase("ldi_fin", 2, 16'h1111, 1'b1);

    drive(STI, 16'h010E, 16'h5001, 16'h2468, 3'd0, 1'b0, 16'h0000);
    req("sti_ptr", 16'h5000, 1'b1, 1'b0, 2'b11);
    phase("sti_ptr", 0, 16'h7003, 1'b0);
    req("sti_fin", 16'h7002, 1'b0, 1'b1, 2'b11);
    chk("sti_wdata", {16'h0, D_mem_wdata}, 32'h00002468);
    phase("sti_fin", 1, 16'h0000, 1'b1);

    drive(STW, 16'h0110, 16'h8003, 16'h55AA, 3'd0, 1'b0, 16'h0000);
    req("stw", 16'h8002, 1'b0, 1'b1, 2'b11);
    chk("stw_wdata", {16'h0, D_mem_wdata}, 32'h000055AA);
    phase("stw", 0, 16'h0000, 1'b1);

    // LDI interrupted by reset while waiting in the indirect phase.
    drive(LDI, 16'h0112, 16'h5000, 16'h0000, 3'd5, 1'b1, 16'h0000);
    phase("rldi_ptr", 0, 16'h9000, 1'b0);
    req("rldi_fin", 16'h9000, 1'b1, 1'b0, 2'b11);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_req", {30'h0, D_mem_read, D_mem_write}, 32'h0);
    chk("rst_mid_stall", {31'h0, stall_mem}, 32'h0);
    chk("rst_mid_wb", {16'h0, alu_out_wb}, 32'h0);
    chk("rst_mid_wbctl", {11'h0, valid_wb, opcode_wb, pc_wb}, 32'h0);
    sb.delete();
    valid_mem = 1'b0;
    @(negedge clk);
    reset       = 1'b1;
    D_mem_resp  = 1'b1;
    D_mem_rdata = 16'hFFFF;
    #1;
    chk("stray_stall", {31'h0, stall_mem}, 32'h0);
    chk("stray_req", {30'h0, D_mem_read, D_mem_write}, 32'h0);
    @(negedge clk);
    D_mem_resp = 1'b0;

    drive(LDW, 16'h0114, 16'h5000, 16'h0000, 3'd6, 1'b1, 16'h0F0F);
    req("post_rst", 16'h5000, 1'b1, 1'b0, 2'b11);
    phase("post_rst", 0, 16'h0F0F, 1'b1);
    valid_mem = 1'b0;
    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

LC-3b pipeline MEM stage: sits directly downstream of the EX/MEM register and consumes its ALU result, store data, opcode and PC. It drives the D-cache handshake for LDW/LDB/STW/STB/LDI/STI, and stalls the pipeline until the access completes. It holds a two-phase indirect sequencer and registers results into the MEM/WB pipeline register.

## Interface
- No parameters (widths fixed by `lc3b_types`).
- `clk  in  1`  pipeline clock, all state on rising edge.
- `reset  in  1`  asynchronous, active-low (asserted at 0); clears all state immediately.
- `valid_mem  in  1`  EX/MEM register holds a live instruction.
- `opcode_mem  in  4`  instruction opcode.
- `pc_mem  in  16`  PC of the instruction (passed through).
- `alu_out_mem  in  16`  effective address, or ALU result for non-memory ops.
- `sr2_mem  in  16`  store data.
- `dest_mem  in  3`  destination register.
- `ld_reg_mem  in  1`  instruction writes the register file.
- `D_mem_address  out  16`, `D_mem_read  out  1`, `D_mem_write  out  1`, `mem_byte_enable  out  2`, `D_mem_wdata  out  16`  D-cache request.
- `D_mem_resp  in  1`, `D_mem_rdata  in  16`  D-cache response.
- `stall_mem  out  1`  freeze all upstream pipeline registers this cycle.
- `valid_wb  out  1`, `opcode_wb  out  4`, `pc_wb  out  16`, `alu_out_wb  out  16`, `mem_data_wb  out  16`, `dest_wb  out  3`, `ld_reg_wb  out  1`  MEM/WB register.

## Operation
- Memory op is `valid_mem` and opcode one of LDB 0010, STB 0011, LDW 0110, STW 0111, LDI 1010, STI 1011. All other opcodes pass through untouched.
- Phase FSM, 2 states:
  - `PH_DIRECT` (reset state): address is `alu_out_mem`.
  - `PH_INDIRECT`: address is the `ind_addr` register.
- LDI/STI in `PH_DIRECT`:
  - Issue a word read.
  - On `D_mem_resp`, capture `D_mem_rdata` into `ind_addr` and go to `PH_INDIRECT`.
  - There the final access (read for LDI, write for STI) is issued.
  - On `D_mem_resp`, the instruction completes and the FSM returns to `PH_DIRECT`.
- All other memory ops complete on the first `D_mem_resp` in `PH_DIRECT`.
- Requests are combinational from the current inputs and phase, and are held steady until `D_mem_resp`. Read and write are never asserted together.
- Word ops (LDW/STW/LDI/STI and the indirect pointer read):
  - Address bit 0 is forced to 0.
  - `mem_byte_enable` = 11.
  - `D_mem_wdata` = `sr2_mem`.
- Byte ops use the address unmodified.
  - STB: `mem_byte_enable` = 01 if addr[0]=0, 10 if addr[0]=1; `D_mem_wdata` = {sr2[7:0], sr2[7:0]}.
  - LDB: `mem_byte_enable` = 11; result = ZEXT of byte addr[0] of `D_mem_rdata`.
- `stall_mem` = memory op AND NOT (`D_mem_resp` AND final phase).
- MEM/WB register loads when `stall_mem`=0.
  - `mem_data_wb` gets the load result (0 for non-loads).
  - Other outputs copy their inputs.
  - `valid_wb` = `valid_mem`.
  - While stalled, MEM/WB holds its value and `valid_wb` is cleared to 0 (bubble).
- `D_mem_resp` with no request outstanding is ignored.
- Non-memory or `valid_mem`=0: no request; `D_mem_read` = `D_mem_write` = 0.

## Timing
- Reset (asynchronous): phase = `PH_DIRECT`, `ind_addr` = 0, all `*_wb` outputs = 0.
  - Request outputs fall to 0 combinationally while reset is asserted.
  - A response arriving after reset releases is ignored unless a new request has been issued.
- Non-memory op: 1 cycle, MEM/WB updated at the next edge.
- Direct access with response at cycle k after issue: stalls k cycles, MEM/WB loaded at the edge ending cycle k.
- Indirect access: pointer read, then the final access starts the cycle after the first response (no idle cycle). Stall covers both phases.
- `D_mem_resp` in the same cycle as the request is legal: zero stall cycles for direct ops.
- Upstream holds the EX/MEM inputs constant while `stall_mem`=1; the block relies on this.

## Structure
- `lc3b_types` additions:
  - `lc3b_opcode` enum values: op_ldb, op_stb, op_ldw, op_stw, op_ldi, op_sti.
  - `lc3b_reg` (3 bits).
  - `lc3b_mem_wmask` (2 bits).
  - `mem_phase_t` {`PH_DIRECT`, `PH_INDIRECT`}.
  - `lc3b_word` is reused.
- Sub-module `mem_byte_align`: combinational; generates the write mask and replicated write data, and extracts the zero-extended load byte. Instantiated once.
- Top level holds the phase FSM, `ind_addr`, stall logic and the MEM/WB register.

## Test plan
- ADD, alu_out_mem=0x1234, ld_reg=1 -> no request, stall_mem=0, next edge alu_out_wb=0x1234, valid_wb=1.
- LDW addr 0x3001, resp after 3 cycles with rdata 0xBEEF -> D_mem_address=0x3000, byte_enable=11, stall 3 cycles with valid_wb=0, then mem_data_wb=0xBEEF.
- STB addr 0x4005, sr2=0x00A7 -> D_mem_write=1, byte_enable=10, wdata=0xA7A7; LDB same address with rdata 0xA7C3 -> mem_data_wb=0x00A7.
- LDI addr 0x5000: first resp rdata 0x6002, second resp rdata 0x1111 -> second request address=0x6002, mem_data_wb=0x1111; STI follows the same sequence with D_mem_write=1 on the second access.
- Same-cycle resp on STW -> stall_mem=0, no extra cycle.
- Reset low mid-LDI (in `PH_INDIRECT`) -> requests drop immediately, phase=`PH_DIRECT`, all `*_wb` = 0; a stray resp after release is ignored.
